// File: rtl/multicycle_ctrl_unit_if.sv
// multicycle_ctrl_unit_if: instruction/data memory request-ready handshake bundle
interface multicycle_ctrl_unit_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;
  modport master (output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
  modport slave (input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: fetch/decode/exec/mem/wb sequencer with branch resolution, memory timeout and stall
module multicycle_ctrl_unit #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 4,
  parameter int RET_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_ctrl_unit_if.master mem_bus,
  input  logic [3:0]             i_opcode,
  input  logic [3:0]             i_opcodeex,
  input  logic [3:0]             i_cond,
  input  logic [4:0]             i_flags,
  input  logic                   i_stall,
  output logic                   o_ir_en,
  output logic                   o_alu_en,
  output logic                   o_a_imm_sel,
  output logic                   o_shift_imm,
  output logic                   o_lui_sel,
  output logic                   o_mov_sel,
  output logic                   o_psr_we,
  output logic                   o_rf_we,
  output logic [1:0]             o_b_sel,
  output logic [1:0]             o_wb_sel,
  output logic                   o_pc_inc,
  output logic                   o_pc_disp,
  output logic                   o_pc_jump,
  output logic                   o_link,
  output logic                   o_illegal,
  output logic                   o_bus_err,
  output logic [RET_W-1:0]       o_retired
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_PC = 3'd6;
  localparam logic [3:0] C_NOP = 4'd0, C_ALU = 4'd1, C_ALUI = 4'd2, C_MOV = 4'd3;
  localparam logic [3:0] C_CMP = 4'd4, C_CMPI = 4'd5, C_LSH = 4'd6, C_LSHI = 4'd7;
  localparam logic [3:0] C_LUI = 4'd8, C_LOAD = 4'd9, C_STOR = 4'd10, C_MOVI = 4'd11;
  localparam logic [3:0] C_JAL = 4'd12, C_JC = 4'd13, C_BC = 4'd14, C_ILL = 4'd15;
  logic [2:0] r_state, w_next;
  logic [3:0] r_cls, w_cls;
  logic [CNT_W-1:0] r_cnt;
  logic [RET_W-1:0] r_ret;
  logic [15:0] w_ctab;
  logic w_fetch, w_dec, w_exec, w_mem, w_wb, w_pc, w_run;
  logic w_rdy, w_wait, w_tout, w_take, w_imm, w_disp, w_jump;
  assign w_fetch = r_state == S_FETCH;
  assign w_dec = r_state == S_DEC;
  assign w_exec = r_state == S_EXEC;
  assign w_mem = r_state == S_MEM;
  assign w_wb = r_state == S_WB;
  assign w_pc = r_state == S_PC;
  assign w_run = ~i_stall;
  assign w_rdy = w_fetch ? mem_bus.imem_ready : mem_bus.dmem_ready;
  assign w_wait = (w_fetch | w_mem) & ~w_rdy;
  assign w_tout = w_wait & (r_cnt == CNT_W'(TIMEOUT));
  always_comb begin
    case (i_opcode)
      4'b0000: w_cls = (i_opcodeex == 4'b0000) ? C_NOP : (i_opcodeex == 4'b1101) ? C_MOV :
                       (i_opcodeex == 4'b1011) ? C_CMP : C_ALU;
      4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b1001: w_cls = C_ALUI;
      4'b1011: w_cls = C_CMPI;
      4'b1000: w_cls = (i_opcodeex == 4'b0100) ? C_LSH : (i_opcodeex[3:1] == 3'b000) ? C_LSHI : C_ILL;
      4'b0100: w_cls = (i_opcodeex == 4'b0000) ? C_LOAD : (i_opcodeex == 4'b0100) ? C_STOR :
                       (i_opcodeex == 4'b1000) ? C_JAL : (i_opcodeex == 4'b1100) ? C_JC : C_ILL;
      4'b1100: w_cls = C_BC;
      4'b1101: w_cls = C_MOVI;
      4'b1111: w_cls = C_LUI;
      default: w_cls = C_ILL;
    endcase
  end
  // indexed by cond; flags are {N,F,Z,L,C}
  assign w_ctab = {1'b0, 1'b1, i_flags[4] | i_flags[2], ~i_flags[4] & ~i_flags[2],
                   i_flags[1] | i_flags[2], ~i_flags[1] & ~i_flags[2], ~i_flags[3], i_flags[3],
                   ~i_flags[4], i_flags[4], ~i_flags[1], i_flags[1], ~i_flags[0], i_flags[0],
                   ~i_flags[2], i_flags[2]};
  assign w_take = w_ctab[i_cond];
  always_comb begin
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: w_next = mem_bus.imem_ready ? S_DEC : S_FETCH;
      S_DEC: w_next = (w_cls inside {C_NOP, C_ILL, C_JC, C_BC}) ? S_PC :
                      (w_cls inside {C_LOAD, C_STOR}) ? S_MEM :
                      (w_cls inside {C_MOVI, C_JAL}) ? S_WB : S_EXEC;
      S_EXEC: w_next = (r_cls inside {C_CMP, C_CMPI}) ? S_PC : S_WB;
      S_MEM: w_next = mem_bus.dmem_ready ? ((r_cls == C_LOAD) ? S_WB : S_PC) : w_tout ? S_PC : S_MEM;
      S_WB: w_next = S_PC;
      default: w_next = S_FETCH;
    endcase
  end
  // the wait counter is zero whenever the previous cycle was not a wait, so entry clears it for free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cls <= C_NOP;
      r_cnt <= '0;
      r_ret <= '0;
    end else if (w_run) begin
      r_state <= w_next;
      r_cls <= w_dec ? w_cls : r_cls;
      r_cnt <= (w_wait & ~w_tout) ? r_cnt + CNT_W'(1) : '0;
      r_ret <= w_pc ? r_ret + RET_W'(1) : r_ret;
    end
  end
  assign w_imm = r_cls inside {C_ALUI, C_CMPI};
  assign w_disp = (r_cls == C_BC) & w_take;
  assign w_jump = (r_cls == C_JAL) | ((r_cls == C_JC) & w_take);
  assign mem_bus.imem_req = w_fetch;
  assign mem_bus.dmem_req = w_mem;
  assign mem_bus.dmem_we = w_mem & (r_cls == C_STOR) & w_run;
  assign o_ir_en = w_fetch & mem_bus.imem_ready & w_run;
  assign o_alu_en = w_exec;
  assign o_a_imm_sel = w_exec & w_imm;
  assign o_b_sel = ~w_exec ? 2'b00 : w_imm ? 2'b10 : (r_cls inside {C_LSH, C_LSHI}) ? 2'b11 : 2'b00;
  assign o_shift_imm = w_exec & (r_cls inside {C_LSHI, C_LUI});
  assign o_lui_sel = w_exec & (r_cls == C_LUI);
  assign o_mov_sel = w_exec & (r_cls == C_MOV);
  assign o_psr_we = w_exec & (r_cls inside {C_CMP, C_CMPI}) & w_run;
  assign o_rf_we = w_wb & w_run;
  assign o_wb_sel = ~w_wb ? 2'b00 : (r_cls == C_LOAD) ? 2'b01 : (r_cls == C_MOVI) ? 2'b10 :
                    (r_cls == C_JAL) ? 2'b11 : 2'b00;
  assign o_link = w_wb & (r_cls == C_JAL) & w_run;
  assign o_pc_disp = w_pc & w_run & w_disp;
  assign o_pc_jump = w_pc & w_run & w_jump;
  assign o_pc_inc = w_pc & w_run & ~w_disp & ~w_jump;
  assign o_illegal = w_dec & (w_cls == C_ILL) & w_run;
  assign o_bus_err = w_tout & w_run;
  assign o_retired = r_ret;
endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// tb_multicycle_ctrl_unit: randomized instruction streams checked cycle by cycle against a transaction-level model
module tb_multicycle_ctrl_unit;
  localparam int TO = 15;
  typedef struct packed {
    logic imem_req, dmem_req, dmem_we, ir_en, alu_en, a_imm_sel, shift_imm, lui_sel, mov_sel, psr_we, rf_we;
    logic [1:0] b_sel, wb_sel;
    logic pc_inc, pc_disp, pc_jump, link, illegal, bus_err;
  } outs_t;
  typedef struct packed {
    logic [3:0] op, ext, cnd;
    logic [4:0] flg;
    logic ir, dr, st, ret;
    outs_t o;
  } cyc_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  multicycle_ctrl_unit_if bus ();
  multicycle_ctrl_unit_if bus2 ();
  assign bus2.imem_ready = bus.imem_ready;
  assign bus2.dmem_ready = bus.dmem_ready;
  logic [3:0] opcode, opcodeex, cond;
  logic [4:0] flags;
  logic stall;
  logic ir_en, alu_en, a_imm_sel, shift_imm, lui_sel, mov_sel, psr_we, rf_we;
  logic pc_inc, pc_disp, pc_jump, link, illegal, bus_err;
  logic [1:0] b_sel, wb_sel;
  logic [15:0] o_retired;
  logic d2_ir_en, d2_alu_en, d2_a_imm, d2_shift, d2_lui, d2_mov, d2_psr, d2_rf;
  logic d2_inc, d2_disp, d2_jump, d2_link, d2_ill, d2_berr;
  logic [1:0] d2_bsel, d2_wbsel, o_retired2;
  multicycle_ctrl_unit u_dut (
    .clk(clk), .rst(rst), .mem_bus(bus.master), .i_opcode(opcode), .i_opcodeex(opcodeex), .i_cond(cond),
    .i_flags(flags), .i_stall(stall), .o_ir_en(ir_en), .o_alu_en(alu_en), .o_a_imm_sel(a_imm_sel),
    .o_shift_imm(shift_imm), .o_lui_sel(lui_sel), .o_mov_sel(mov_sel), .o_psr_we(psr_we), .o_rf_we(rf_we),
    .o_b_sel(b_sel), .o_wb_sel(wb_sel), .o_pc_inc(pc_inc), .o_pc_disp(pc_disp), .o_pc_jump(pc_jump),
    .o_link(link), .o_illegal(illegal), .o_bus_err(bus_err), .o_retired(o_retired));
  multicycle_ctrl_unit #(.RET_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .mem_bus(bus2.master), .i_opcode(opcode), .i_opcodeex(opcodeex), .i_cond(cond),
    .i_flags(flags), .i_stall(stall), .o_ir_en(d2_ir_en), .o_alu_en(d2_alu_en), .o_a_imm_sel(d2_a_imm),
    .o_shift_imm(d2_shift), .o_lui_sel(d2_lui), .o_mov_sel(d2_mov), .o_psr_we(d2_psr), .o_rf_we(d2_rf),
    .o_b_sel(d2_bsel), .o_wb_sel(d2_wbsel), .o_pc_inc(d2_inc), .o_pc_disp(d2_disp), .o_pc_jump(d2_jump),
    .o_link(d2_link), .o_illegal(d2_ill), .o_bus_err(d2_berr), .o_retired(o_retired2));
  outs_t act, act2;
  assign act = {bus.imem_req, bus.dmem_req, bus.dmem_we, ir_en, alu_en, a_imm_sel, shift_imm, lui_sel,
                mov_sel, psr_we, rf_we, b_sel, wb_sel, pc_inc, pc_disp, pc_jump, link, illegal, bus_err};
  assign act2 = {bus2.imem_req, bus2.dmem_req, bus2.dmem_we, d2_ir_en, d2_alu_en, d2_a_imm, d2_shift, d2_lui,
                 d2_mov, d2_psr, d2_rf, d2_bsel, d2_wbsel, d2_inc, d2_disp, d2_jump, d2_link, d2_ill, d2_berr};
  int checks = 0, errors = 0;
  int n_cyc = 0, n_disp = 0, n_dreq = 0, n_rf = 0, n_berr = 0, n_psr = 0;
  logic [15:0] ret_model = 0;
  cyc_t q[$];
  logic [3:0] exts [8] = '{4'h0, 4'hd, 4'hb, 4'h4, 4'h1, 4'h8, 4'hc, 4'h5};
  logic [4:0] fls [5] = '{5'b00000, 5'b00100, 5'b00010, 5'b10000, 5'b00110};
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, a, e, $time);
    end
  endtask
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  function automatic string cls_of(input logic [3:0] op, input logic [3:0] ex);
    if (op == 4'd0) return ex == 4'd0 ? "NOP" : ex == 4'd13 ? "MOV" : ex == 4'd11 ? "CMP" : "ALU";
    if (op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd9}) return "ALUI";
    if (op == 4'd11) return "CMPI";
    if (op == 4'd8) return ex == 4'd4 ? "LSH" : ex <= 4'd1 ? "LSHI" : "ILL";
    if (op == 4'd4) return ex == 4'd0 ? "LOAD" : ex == 4'd4 ? "STOR" : ex == 4'd8 ? "JAL" : ex == 4'd12 ? "JC" : "ILL";
    if (op == 4'd12) return "BC";
    if (op == 4'd13) return "MOVI";
    if (op == 4'd15) return "LUI";
    return "ILL";
  endfunction
  function automatic logic cond_ok(input logic [3:0] c, input logic [4:0] f);
    logic n, ff, z, l, cy;
    {n, ff, z, l, cy} = f;
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cy;
      4'd3: return !cy;
      4'd4: return l;
      4'd5: return !l;
      4'd6: return n;
      4'd7: return !n;
      4'd8: return ff;
      4'd9: return !ff;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic cyc_t mk(input logic ir, input logic dr, input outs_t o, input logic r);
    cyc_t e;
    e = '0;
    e.ir = ir;
    e.dr = dr;
    e.o = o;
    e.ret = r;
    return e;
  endfunction
  function automatic outs_t frozen(input outs_t o);
    outs_t m;
    m = o;
    {m.dmem_we, m.ir_en, m.psr_we, m.rf_we, m.pc_inc, m.pc_disp, m.pc_jump, m.link, m.illegal, m.bus_err} = '0;
    return m;
  endfunction
  // expands one instruction into its expected cycles, then splices st_len frozen copies before cycle st_at
  task automatic add_instr(input logic [3:0] op, input logic [3:0] ex, input logic [3:0] cn, input logic [4:0] fl,
                           input int iw, input int dw, input int st_at, input int st_len);
    string k;
    outs_t o;
    cyc_t c[$];
    cyc_t e, h;
    logic exe, cmp, imm, sh, abort, tk;
    int n;
    k = cls_of(op, ex);
    exe = k == "ALU" || k == "ALUI" || k == "MOV" || k == "CMP" || k == "CMPI" || k == "LSH" || k == "LSHI" || k == "LUI";
    cmp = k == "CMP" || k == "CMPI";
    imm = k == "ALUI" || k == "CMPI";
    sh = k == "LSH" || k == "LSHI";
    abort = 0;
    for (int w = 0; w < iw; w++) begin
      o = '0; o.imem_req = 1; o.bus_err = (w % (TO + 1)) == TO;
      c.push_back(mk(0, rb(), o, 0));
    end
    o = '0; o.imem_req = 1; o.ir_en = 1;
    c.push_back(mk(1, rb(), o, 0));
    o = '0; o.illegal = k == "ILL";
    c.push_back(mk(rb(), rb(), o, 0));
    if (exe) begin
      o = '0; o.alu_en = 1; o.a_imm_sel = imm; o.b_sel = imm ? 2'd2 : sh ? 2'd3 : 2'd0;
      o.shift_imm = k == "LSHI" || k == "LUI"; o.lui_sel = k == "LUI"; o.mov_sel = k == "MOV"; o.psr_we = cmp;
      c.push_back(mk(rb(), rb(), o, 0));
    end
    if (k == "LOAD" || k == "STOR") begin
      abort = dw > TO;
      n = abort ? TO + 1 : dw + 1;
      for (int m = 0; m < n; m++) begin
        o = '0; o.dmem_req = 1; o.dmem_we = k == "STOR"; o.bus_err = abort && m == n - 1;
        c.push_back(mk(rb(), !abort && m == n - 1, o, 0));
      end
    end
    if ((exe && !cmp) || (k == "LOAD" && !abort) || k == "MOVI" || k == "JAL") begin
      o = '0; o.rf_we = 1; o.link = k == "JAL";
      o.wb_sel = k == "LOAD" ? 2'd1 : k == "MOVI" ? 2'd2 : k == "JAL" ? 2'd3 : 2'd0;
      c.push_back(mk(rb(), rb(), o, 0));
    end
    tk = cond_ok(cn, fl);
    o = '0; o.pc_disp = k == "BC" && tk; o.pc_jump = k == "JAL" || (k == "JC" && tk);
    o.pc_inc = !o.pc_disp && !o.pc_jump;
    c.push_back(mk(rb(), rb(), o, 1));
    foreach (c[i]) begin
      e = c[i]; e.op = op; e.ext = ex; e.cnd = cn; e.flg = fl;
      if (i == st_at)
        for (int s = 0; s < st_len; s++) begin
          h = e; h.st = 1; h.ret = 0; h.ir = rb(); h.dr = rb(); h.o = frozen(e.o);
          q.push_back(h);
        end
      q.push_back(e);
    end
  endtask
  task automatic run_q(input int n);
    cyc_t e;
    while (q.size() > 0 && n != 0) begin
      n--;
      e = q.pop_front();
      opcode = e.op; opcodeex = e.ext; cond = e.cnd; flags = e.flg;
      bus.imem_ready = e.ir; bus.dmem_ready = e.dr; stall = e.st;
      @(negedge clk);
      chk("outs", act, e.o);
      chk("outs_ret2", act2, e.o);
      chk("retired", o_retired, ret_model);
      chk("retired2", o_retired2, ret_model[1:0]);
      n_cyc++; n_disp += act.pc_disp; n_dreq += act.dmem_req; n_rf += act.rf_we;
      n_berr += act.bus_err; n_psr += act.psr_we;
      @(posedge clk);
      #1;
      if (e.ret) ret_model++;
    end
  endtask
  initial begin
    int p_cyc, p_dreq, p_rf, p_berr, p_psr, p_disp, iw, dw, sa;
    logic [3:0] op, ex;
    stall = 0; opcode = 0; opcodeex = 0; cond = 0; flags = 0;
    bus.imem_ready = 0; bus.dmem_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    opcode = 4'b0101; opcodeex = 4'h3; bus.imem_ready = 1; bus.dmem_ready = 1;
    @(negedge clk); chk("reset_outs", act, 0); chk("reset_retired", o_retired, 0);
    @(negedge clk); chk("addi_fetch", {act.imem_req, act.ir_en}, 2'b11);
    repeat (2) @(negedge clk); chk("addi_exec", {act.alu_en, act.a_imm_sel, act.b_sel}, 4'b1110);
    @(negedge clk); chk("addi_wb", {act.rf_we, act.wb_sel}, 3'b100);
    @(negedge clk); chk("addi_pcupd", {act.pc_inc, act.pc_disp, act.pc_jump}, 3'b100);
    @(posedge clk); #1 chk("addi_retired", o_retired, 1);
    ret_model = 1;
    add_instr(4'b1110, 4'h0, 4'h0, 5'h0, 0, 0, -1, 0);
    add_instr(4'b1100, 4'h0, 4'b1110, 5'h0, 0, 0, -1, 0);
    add_instr(4'b0000, 4'b1011, 4'h0, 5'h0, 0, 0, -1, 0);
    run_q(-1);
    chk("wrap_retired16", o_retired, 4);
    chk("wrap_retired2", o_retired2, 0);
    p_disp = n_disp;
    foreach (fls[f])
      for (int c = 0; c < 16; c++) add_instr(4'b1100, 4'($urandom), 4'(c), fls[f], 0, 0, -1, 0);
    run_q(-1);
    chk("sweep_disp_count", n_disp - p_disp, 40);
    p_dreq = n_dreq; p_rf = n_rf;
    add_instr(4'b0100, 4'b0000, 4'h0, 5'h0, 0, 3, -1, 0);
    run_q(-1);
    chk("load_dreq_cycles", n_dreq - p_dreq, 4);
    chk("load_rf_we", n_rf - p_rf, 1);
    p_dreq = n_dreq; p_rf = n_rf; p_berr = n_berr;
    add_instr(4'b0100, 4'b0100, 4'h0, 5'h0, 0, 99, -1, 0);
    run_q(-1);
    chk("stor_timeout_dreq", n_dreq - p_dreq, 16);
    chk("stor_timeout_berr", n_berr - p_berr, 1);
    chk("stor_timeout_rf", n_rf - p_rf, 0);
    p_cyc = n_cyc; p_psr = n_psr;
    add_instr(4'b1011, 4'h2, 4'h0, 5'h0, 0, 0, 2, 4);
    run_q(-1);
    chk("cmpi_stall_latency", n_cyc - p_cyc, 8);
    chk("cmpi_stall_psr", n_psr - p_psr, 1);
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom);
      ex = ($urandom % 4 != 0) ? exts[$urandom % 8] : 4'($urandom);
      iw = ($urandom % 12 == 0) ? 17 : int'($urandom % 3);
      dw = ($urandom % 8 == 0) ? 20 : int'($urandom % 4);
      sa = ($urandom % 4 == 0) ? int'($urandom % 7) : -1;
      add_instr(op, ex, 4'($urandom), 5'($urandom), iw, dw, sa, 1 + int'($urandom % 3));
      run_q(-1);
    end
    add_instr(4'b0000, 4'b0001, 4'h0, 5'h0, 0, 0, -1, 0);
    run_q(3);
    rst = 1;
    #1 chk("midrst_outs", act, 0);
    chk("midrst_retired", o_retired, 0);
    #1 rst = 0;
    q.delete();
    ret_model = 0;
    q.push_back(mk(0, 0, '0, 0));
    add_instr(4'b0001, 4'h7, 4'h0, 5'h0, 0, 0, -1, 0);
    run_q(-1);
    chk("post_rst_retired", o_retired, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
